tcb_lib_demultiplexer: RTL

TCB_LIB_DEMULTIPLEXER -- requirements
Module: tcb_lib_demultiplexer

---
 rtl/tcb_lib_demultiplexer_if.sv | 51 +++++
 rtl/tcb_lib_demultiplexer.sv | 105 ++++++++++
 2 files changed

// File: rtl/tcb_lib_demultiplexer_if.sv
// TCB demultiplexer bus bundle: manager request/response and per-port subordinate lines.
// The master modport drives requests and subordinate responses; the slave modport is the demux.
interface tcb_lib_demultiplexer_if #(
    parameter int SPN = 2,
    parameter int ABW = 32,
    parameter int DBW = 32
);
    localparam int SPL = $clog2(SPN);
    localparam int BEN = DBW/8;

    logic [SPL-1:0] sel;

    logic           man_vld;
    logic           man_wen;
    logic [ABW-1:0] man_adr;
    logic [BEN-1:0] man_ben;
    logic [DBW-1:0] man_wdt;
    logic           man_rdy;
    logic           man_rsp;
    logic [DBW-1:0] man_rdt;
    logic           man_err;

    logic           sub_vld [SPN];
    logic           sub_wen [SPN];
    logic [ABW-1:0] sub_adr [SPN];
    logic [BEN-1:0] sub_ben [SPN];
    logic [DBW-1:0] sub_wdt [SPN];
    logic           sub_rdy [SPN];
    logic           sub_err [SPN];
    logic [DBW-1:0] sub_rdt [SPN];

    logic           bsy;

    modport master (
        output sel,
        output man_vld, man_wen, man_adr, man_ben, man_wdt,
        input  man_rdy, man_rsp, man_rdt, man_err,
        input  sub_vld, sub_wen, sub_adr, sub_ben, sub_wdt,
        output sub_rdy, sub_err, sub_rdt,
        input  bsy
    );

    modport slave (
        input  sel,
        input  man_vld, man_wen, man_adr, man_ben, man_wdt,
        output man_rdy, man_rsp, man_rdt, man_err,
        output sub_vld, sub_wen, sub_adr, sub_ben, sub_wdt,
        input  sub_rdy, sub_err, sub_rdt,
        output bsy
    );
endinterface

// File: rtl/tcb_lib_demultiplexer.sv
// TCB demultiplexer: one manager to SPN subordinates, fixed-latency response path.
// Responses are steered by a DLY-deep record of each transfer's select.
module tcb_lib_demultiplexer #(
    parameter int SPN = 2,
    parameter int ABW = 32,
    parameter int DBW = 32,
    parameter int DLY = 1
) (
    input  logic clk,
    input  logic rst,
    tcb_lib_demultiplexer_if.slave bus
);
    localparam int SPL = $clog2(SPN);

    localparam logic [SPL:0] SPNW = SPN[SPL:0];

    typedef struct packed {
        logic           vld;
        logic           unm;
        logic [SPL-1:0] sel;
    } stg_t;

    logic           unm;
    logic           rdy;
    logic           trn;
    logic           rv;
    logic           ru;
    logic [SPL-1:0] rs;

    // Selects past the last port only exist for non-power-of-2 SPN.
    assign unm = ({1'b0, bus.sel} >= SPNW);
    assign trn = bus.man_vld & rdy;

    always_comb begin
        rdy = unm;
        for (int i = 0; i < SPN; i++) begin
            bus.sub_vld[i] = bus.man_vld & (bus.sel == SPL'(i));
            bus.sub_wen[i] = bus.man_wen;
            bus.sub_adr[i] = bus.man_adr;
            bus.sub_ben[i] = bus.man_ben;
            bus.sub_wdt[i] = bus.man_wdt;
            if (bus.sel == SPL'(i)) begin
                rdy = bus.sub_rdy[i];
            end
        end
        bus.man_rdy = rdy;
    end

    generate
        if (DLY == 0) begin : g_comb
            assign rv      = trn;
            assign ru      = trn & unm;
            assign rs      = bus.sel;
            assign bus.bsy = 1'b0;
        end else begin : g_pipe
            stg_t stg [DLY];
            logic any;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    for (int i = 0; i < DLY; i++) begin
                        stg[i] <= '0;
                    end
                end else begin
                    stg[0] <= '{vld: trn,
                                unm: trn & unm,
                                sel: trn ? bus.sel : '0};
                    for (int i = 1; i < DLY; i++) begin
                        stg[i] <= stg[i-1];
                    end
                end
            end

            always_comb begin
                any = 1'b0;
                for (int i = 0; i < DLY; i++) begin
                    any = any | stg[i].vld;
                end
            end

            assign rv      = stg[DLY-1].vld;
            assign ru      = stg[DLY-1].unm;
            assign rs      = stg[DLY-1].sel;
            assign bus.bsy = any;
        end
    endgenerate

    always_comb begin
        bus.man_rsp = rv;
        bus.man_rdt = '0;
        bus.man_err = 1'b0;
        if (rv) begin
            if (ru) begin
                bus.man_err = 1'b1;
            end else begin
                for (int i = 0; i < SPN; i++) begin
                    if (rs == SPL'(i)) begin
                        bus.man_rdt = bus.sub_rdt[i];
                        bus.man_err = bus.sub_err[i];
                    end
                end
            end
        end
    end
endmodule
